// File: rtl/control_pipe.sv
// control_pipe: registered control path from decode through EX, MEM and WB.
// Decodes the opcode into the control bundle and carries it down the pipe.
// Load-use hazards stall decode, and a pending data-memory access freezes
// EX and MEM. Flush kills the decode and EX instructions. A saturating
// counter records stalled decode cycles.
//
// Handshake: the decode slot offers an instruction with in_valid. It is taken
// at a rising edge only when in_valid and in_ready are both high. in_ready is
// combinational from the current inputs and pipe state and does not depend on
// in_valid except through the hazard term. When in_ready is low the slot must
// keep presenting the same instruction. in_ready is forced low during reset.
module control_pipe #(
  parameter int OPCODE_W   = 5,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  flush,
  input  logic                  mem_ready,
  output logic                  in_ready,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_jump,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_valid,
  output logic                  wb_regwrite,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [CNT_W-1:0]      stall_count
);

  // Decoded fields of the decode-slot instruction
  logic [1:0] op_class;
  logic [2:0] op_func;
  logic       dec_regwrite, dec_mem_read, dec_mem_write;
  logic       dec_mem_to_reg, dec_alu_src, dec_jump;
  logic       use_rs1, use_rs2;

  // EX stage registers
  logic                  ex_valid_q, ex_regwrite_q, ex_mem_read_q, ex_mem_write_q;
  logic                  ex_mem_to_reg_q, ex_alu_src_q, ex_jump_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  ex_valid_d, ex_regwrite_d, ex_mem_read_d, ex_mem_write_d;
  logic                  ex_mem_to_reg_d, ex_alu_src_d, ex_jump_d;
  logic [REG_ADDR_W-1:0] ex_rd_d;

  // MEM stage registers
  logic                  mem_valid_q, mem_regwrite_q, mem_read_q, mem_write_q;
  logic                  mem_to_reg_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  mem_valid_d, mem_regwrite_d, mem_read_d, mem_write_d;
  logic                  mem_to_reg_d;
  logic [REG_ADDR_W-1:0] mem_rd_d;

  // WB stage registers
  logic                  wb_valid_q, wb_regwrite_q, wb_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic                  wb_valid_d, wb_regwrite_d, wb_mem_to_reg_d;
  logic [REG_ADDR_W-1:0] wb_rd_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hazard, freeze, accept;

  assign op_class = opcode[OPCODE_W-1 -: 2];
  assign op_func  = opcode[2:0];

  // Opcode decode into the control bundle and source-register usage
  always_comb begin
    dec_regwrite   = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_jump       = 1'b0;
    use_rs1        = 1'b0;
    use_rs2        = 1'b0;
    unique case (op_class)
      2'b00: begin
        if (op_func != 3'b101) begin
          dec_alu_src = 1'b1;
          dec_jump    = 1'b1;
        end
      end
      2'b01: begin
        use_rs1 = 1'b1;
        unique case (op_func)
          3'b101: begin
            dec_regwrite   = 1'b1;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_alu_src    = 1'b1;
          end
          3'b110: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
          end
          default: begin
            dec_regwrite = 1'b1;
            dec_alu_src  = 1'b1;
          end
        endcase
      end
      default: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec_regwrite = 1'b1;
      end
    endcase
  end

  // A load in EX whose result a decode source needs cannot be bypassed in time
  assign hazard = in_valid & ex_valid_q & ex_mem_read_q &
                  ((use_rs1 & (ex_rd_q == rs1)) | (use_rs2 & (ex_rd_q == rs2)));
  assign freeze = mem_valid_q & (mem_read_q | mem_write_q) & ~mem_ready;
  assign in_ready = rst & ~hazard & ~freeze & ~flush;
  assign accept   = in_valid & in_ready;

  // EX next state: hold under freeze (unless flushed), else load decode or bubble
  always_comb begin
    ex_valid_d      = ex_valid_q;
    ex_regwrite_d   = ex_regwrite_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_mem_to_reg_d = ex_mem_to_reg_q;
    ex_alu_src_d    = ex_alu_src_q;
    ex_jump_d       = ex_jump_q;
    ex_rd_d         = ex_rd_q;
    if (!freeze || flush) begin
      ex_valid_d      = accept;
      ex_regwrite_d   = accept & dec_regwrite;
      ex_mem_read_d   = accept & dec_mem_read;
      ex_mem_write_d  = accept & dec_mem_write;
      ex_mem_to_reg_d = accept & dec_mem_to_reg;
      ex_alu_src_d    = accept & dec_alu_src;
      ex_jump_d       = accept & dec_jump;
      ex_rd_d         = accept ? rd : '0;
    end
  end

  // MEM next state: hold under freeze; flush kills the instruction leaving EX
  always_comb begin
    mem_valid_d    = mem_valid_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    mem_rd_d       = mem_rd_q;
    if (!freeze) begin
      mem_valid_d    = ex_valid_q      & ~flush;
      mem_regwrite_d = ex_regwrite_q   & ~flush;
      mem_read_d     = ex_mem_read_q   & ~flush;
      mem_write_d    = ex_mem_write_q  & ~flush;
      mem_to_reg_d   = ex_mem_to_reg_q & ~flush;
      mem_rd_d       = flush ? '0 : ex_rd_q;
    end
  end

  // WB next state: bubble while MEM waits, otherwise take what MEM holds
  always_comb begin
    wb_valid_d      = mem_valid_q    & ~freeze;
    wb_regwrite_d   = mem_regwrite_q & ~freeze;
    wb_mem_to_reg_d = mem_to_reg_q   & ~freeze;
    wb_rd_d         = freeze ? '0 : mem_rd_q;
  end

  // Stall counter: count refused decode cycles, stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && !in_ready && !(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Pipeline and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q      <= 1'b0;
      ex_regwrite_q   <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
      ex_alu_src_q    <= 1'b0;
      ex_jump_q       <= 1'b0;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_regwrite_q  <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_rd_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
      cnt_q           <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_regwrite_q   <= ex_regwrite_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_jump_q       <= ex_jump_d;
      ex_rd_q         <= ex_rd_d;
      mem_valid_q     <= mem_valid_d;
      mem_regwrite_q  <= mem_regwrite_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      mem_rd_q        <= mem_rd_d;
      wb_valid_q      <= wb_valid_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_q         <= wb_rd_d;
      cnt_q           <= cnt_d;
    end
  end

  // Stage outputs, each control qualified by its stage valid
  assign ex_valid      = ex_valid_q;
  assign ex_alu_src    = ex_valid_q & ex_alu_src_q;
  assign ex_jump       = ex_valid_q & ex_jump_q;
  assign ex_rd         = ex_rd_q;
  assign mem_valid     = mem_valid_q;
  assign mem_read      = mem_valid_q & mem_read_q;
  assign mem_write     = mem_valid_q & mem_write_q;
  assign wb_valid      = wb_valid_q;
  assign wb_regwrite   = wb_valid_q & wb_regwrite_q;
  assign wb_mem_to_reg = wb_valid_q & wb_mem_to_reg_q;
  assign wb_rd         = wb_rd_q;
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: decode-stream table, hand-written corner sequences
// and randomized traffic checked against a stage-list reference model.
module tb_control_pipe;

  localparam int OW = 5;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [OW-1:0] OP_NOP  = 5'b00101;
  localparam logic [OW-1:0] OP_JMP  = 5'b00000;
  localparam logic [OW-1:0] OP_LDD  = 5'b01101;
  localparam logic [OW-1:0] OP_STD  = 5'b01110;
  localparam logic [OW-1:0] OP_ADDI = 5'b01000;
  localparam logic [OW-1:0] OP_R2   = 5'b10000;
  localparam logic [OW-1:0] OP_R1   = 5'b11000;

  logic          clk, rst, in_valid, flush, mem_ready;
  logic [OW-1:0] opcode;
  logic [AW-1:0] rs1, rs2, rd;
  logic          in_ready, ex_valid, ex_alu_src, ex_jump;
  logic [AW-1:0] ex_rd;
  logic          mem_valid, mem_read, mem_write;
  logic          wb_valid, wb_regwrite, wb_mem_to_reg;
  logic [AW-1:0] wb_rd;
  logic [CW-1:0] stall_count;

  control_pipe #(.OPCODE_W(OW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd), .flush(flush), .mem_ready(mem_ready),
    .in_ready(in_ready), .ex_valid(ex_valid), .ex_alu_src(ex_alu_src),
    .ex_jump(ex_jump), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_read(mem_read), .mem_write(mem_write), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .stall_count(stall_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // One record per occupied stage; an all-zero record is an empty stage.
  typedef struct packed {
    logic          v, rw, mr, mw, m2r, as, j;
    logic [AW-1:0] rd;
  } instr_t;

  instr_t m_ex, m_mem, m_wb;
  instr_t n_ex, n_mem, n_wb;
  int     m_cnt, n_cnt;
  logic   m_rdy;

  int n_checks = 0;
  int n_fail   = 0;
  logic last_ready;

  function automatic instr_t model_decode(input logic [OW-1:0] op, input logic [AW-1:0] d);
    instr_t s;
    logic [4:0] b;
    logic [1:0] c;
    logic [2:0] f;
    c = op[OW-1 -: 2];
    f = op[2:0];
    if (c == 2'b00)      b = 5'b00000;
    else if (c == 2'b01) b = (f == 3'b101) ? 5'b11011 : (f == 3'b110) ? 5'b00101 : 5'b10001;
    else                 b = 5'b10000;
    if (c == 2'b00 && f != 3'b101) b = 5'b00001;
    s     = '0;
    s.v   = 1'b1;
    {s.rw, s.mr, s.mw, s.m2r, s.as} = b;
    s.j   = (c == 2'b00) && (f != 3'b101);
    s.rd  = d;
    return s;
  endfunction

  function automatic int sources_of(input logic [OW-1:0] op);
    logic [1:0] c;
    c = op[OW-1 -: 2];
    return (c == 2'b00) ? 0 : (c == 2'b01) ? 1 : 2;
  endfunction

  task automatic model_eval(input logic v, input logic [OW-1:0] op,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [AW-1:0] d, input logic fl, input logic mr);
    bit hz, fz, dep;
    int ns;
    ns  = sources_of(op);
    dep = (ns >= 1 && m_ex.rd == a1) || (ns == 2 && m_ex.rd == a2);
    hz  = v && m_ex.v && m_ex.mr && dep;
    fz  = m_mem.v && (m_mem.mr || m_mem.mw) && !mr;
    m_rdy = !hz && !fz && !fl;
    n_cnt = (v && !m_rdy && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    if (fz) begin
      n_wb  = '0;
      n_mem = m_mem;
      n_ex  = fl ? instr_t'('0) : m_ex;
    end else begin
      n_wb  = m_mem;
      n_mem = fl ? instr_t'('0) : m_ex;
      n_ex  = (v && m_rdy) ? model_decode(op, d) : instr_t'('0);
    end
  endtask

  task automatic model_reset;
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ex_valid"},      32'(ex_valid),      32'(m_ex.v));
    check({tag, ".ex_alu_src"},    32'(ex_alu_src),    32'(m_ex.as));
    check({tag, ".ex_jump"},       32'(ex_jump),       32'(m_ex.j));
    check({tag, ".ex_rd"},         32'(ex_rd),         32'(m_ex.rd));
    check({tag, ".mem_valid"},     32'(mem_valid),     32'(m_mem.v));
    check({tag, ".mem_read"},      32'(mem_read),      32'(m_mem.mr));
    check({tag, ".mem_write"},     32'(mem_write),     32'(m_mem.mw));
    check({tag, ".wb_valid"},      32'(wb_valid),      32'(m_wb.v));
    check({tag, ".wb_regwrite"},   32'(wb_regwrite),   32'(m_wb.rw));
    check({tag, ".wb_mem_to_reg"}, 32'(wb_mem_to_reg), 32'(m_wb.m2r));
    check({tag, ".wb_rd"},         32'(wb_rd),         32'(m_wb.rd));
    check({tag, ".stall_count"},   32'(stall_count),   m_cnt);
  endtask

  // ---------------- driver tasks ----------------
  // Called with time just past a rising edge; returns #1 after the next one.
  task automatic do_cycle(input string tag, input logic v, input logic [OW-1:0] op,
                          input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] d, input logic fl, input logic mr);
    in_valid = v; opcode = op; rs1 = a1; rs2 = a2; rd = d; flush = fl; mem_ready = mr;
    #1;
    model_eval(v, op, a1, a2, d, fl, mr);
    last_ready = in_ready;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy));
    @(posedge clk);
    m_ex = n_ex; m_mem = n_mem; m_wb = n_wb; m_cnt = n_cnt;
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    do_cycle(tag, 1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("reset");
  endtask

  // ---------------- decode-stream table ----------------
  typedef struct {
    logic          v;
    logic [OW-1:0] op;
    logic [AW-1:0] d;
    logic          e_rdy;
    logic [2:0]    e_ex;    // valid, alu_src, jump
    logic [AW-1:0] e_exrd;
    logic [2:0]    e_mem;   // valid, mem_read, mem_write
    logic [2:0]    e_wb;    // valid, regwrite, mem_to_reg
    logic [AW-1:0] e_wbrd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, OP_NOP,  3'd1, 1'b1, 3'b100, 3'd1, 3'b000, 3'b000, 3'd0};
    vecs[1] = '{1'b1, OP_JMP,  3'd2, 1'b1, 3'b111, 3'd2, 3'b100, 3'b000, 3'd0};
    vecs[2] = '{1'b1, OP_LDD,  3'd3, 1'b1, 3'b110, 3'd3, 3'b100, 3'b100, 3'd1};
    vecs[3] = '{1'b1, OP_STD,  3'd4, 1'b1, 3'b110, 3'd4, 3'b110, 3'b100, 3'd2};
    vecs[4] = '{1'b1, OP_ADDI, 3'd5, 1'b1, 3'b110, 3'd5, 3'b101, 3'b111, 3'd3};
    vecs[5] = '{1'b1, OP_R2,   3'd6, 1'b1, 3'b100, 3'd6, 3'b100, 3'b100, 3'd4};
    vecs[6] = '{1'b1, OP_R1,   3'd7, 1'b1, 3'b100, 3'd7, 3'b100, 3'b110, 3'd5};
    vecs[7] = '{1'b0, OP_NOP,  3'd0, 1'b1, 3'b000, 3'd0, 3'b100, 3'b110, 3'd6};
    vecs[8] = '{1'b0, OP_NOP,  3'd0, 1'b1, 3'b000, 3'd0, 3'b000, 3'b110, 3'd7};
    vecs[9] = '{1'b0, OP_NOP,  3'd0, 1'b1, 3'b000, 3'd0, 3'b000, 3'b000, 3'd0};

    do_reset();

    // Decode stream, each row checked against fixed expectations and the model
    for (int i = 0; i < 10; i++) begin
      do_cycle("table", vecs[i].v, vecs[i].op, 3'd1, 3'd2, vecs[i].d, 1'b0, 1'b1);
      check("table.rdy",   32'(last_ready), 32'(vecs[i].e_rdy));
      check("table.ex",    32'({ex_valid, ex_alu_src, ex_jump}), 32'(vecs[i].e_ex));
      check("table.exrd",  32'(ex_rd), 32'(vecs[i].e_exrd));
      check("table.mem",   32'({mem_valid, mem_read, mem_write}), 32'(vecs[i].e_mem));
      check("table.wb",    32'({wb_valid, wb_regwrite, wb_mem_to_reg}), 32'(vecs[i].e_wb));
      check("table.wbrd",  32'(wb_rd), 32'(vecs[i].e_wbrd));
    end

    // Load-use hazard: one stall cycle, bubble into EX
    do_reset();
    do_cycle("lu", 1'b1, OP_LDD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
    do_cycle("lu", 1'b1, OP_R2,  3'd1, 3'd3, 3'd6, 1'b0, 1'b1);
    check("lu.stall_ready", 32'(last_ready), 32'd0);
    check("lu.bubble",      32'(ex_valid), 32'd0);
    check("lu.count",       32'(stall_count), 32'd1);
    do_cycle("lu", 1'b1, OP_R2,  3'd1, 3'd3, 3'd6, 1'b0, 1'b1);
    check("lu.accept_ready", 32'(last_ready), 32'd1);
    check("lu.accept_rd",    32'(ex_rd), 32'd6);
    check("lu.count_hold",   32'(stall_count), 32'd1);

    // Same sequence without dependency: no stall
    do_reset();
    do_cycle("nolu", 1'b1, OP_LDD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1);
    do_cycle("nolu", 1'b1, OP_R2,  3'd1, 3'd4, 3'd6, 1'b0, 1'b1);
    check("nolu.ready", 32'(last_ready), 32'd1);
    check("nolu.count", 32'(stall_count), 32'd0);

    // Memory wait: STD in MEM frozen for 3 cycles
    do_reset();
    do_cycle("mw", 1'b1, OP_STD,  3'd1, 3'd2, 3'd4, 1'b0, 1'b1);
    do_cycle("mw", 1'b1, OP_ADDI, 3'd1, 3'd2, 3'd5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_cycle("mw", 1'b1, OP_R2, 3'd1, 3'd2, 3'd6, 1'b0, 1'b0);
      check("mw.ready",    32'(last_ready), 32'd0);
      check("mw.wb_valid", 32'(wb_valid), 32'd0);
      check("mw.mem_hold", 32'({mem_valid, mem_write}), 32'b11);
      check("mw.ex_hold",  32'(ex_rd), 32'd5);
    end
    check("mw.count", 32'(stall_count), 32'd3);
    do_cycle("mw", 1'b1, OP_R2, 3'd1, 3'd2, 3'd6, 1'b0, 1'b1);
    check("mw.retire", 32'({wb_valid, wb_regwrite, wb_rd}), 32'({1'b1, 1'b0, 3'd4}));

    // Flush: decode and EX instructions vanish, MEM instruction retires
    do_reset();
    do_cycle("fl", 1'b1, OP_ADDI, 3'd1, 3'd2, 3'd5, 1'b0, 1'b1);
    do_cycle("fl", 1'b1, OP_R2,   3'd1, 3'd2, 3'd6, 1'b0, 1'b1);
    do_cycle("fl", 1'b1, OP_R1,   3'd1, 3'd2, 3'd7, 1'b1, 1'b1);
    check("fl.ex_valid",  32'(ex_valid), 32'd0);
    check("fl.mem_valid", 32'(mem_valid), 32'd0);
    check("fl.wb_retire", 32'({wb_valid, wb_rd}), 32'({1'b1, 3'd5}));
    idle("fl");
    check("fl.no_wb1", 32'(wb_valid), 32'd0);
    idle("fl");
    check("fl.no_wb2", 32'(wb_valid), 32'd0);

    // Flush during freeze: EX clears, MEM holds
    do_reset();
    do_cycle("ff", 1'b1, OP_STD,  3'd1, 3'd2, 3'd4, 1'b0, 1'b1);
    do_cycle("ff", 1'b1, OP_ADDI, 3'd1, 3'd2, 3'd5, 1'b0, 1'b1);
    do_cycle("ff", 1'b1, OP_R2,   3'd1, 3'd2, 3'd6, 1'b1, 1'b0);
    check("ff.ex_clear", 32'(ex_valid), 32'd0);
    check("ff.mem_hold", 32'({mem_valid, mem_write}), 32'b11);
    check("ff.wb_bub",   32'(wb_valid), 32'd0);
    idle("ff");
    check("ff.retire",   32'({wb_valid, wb_rd}), 32'({1'b1, 3'd4}));
    check("ff.mem_empty", 32'(mem_valid), 32'd0);

    // Saturation, then asynchronous reset in the middle of a freeze
    do_reset();
    do_cycle("sat", 1'b1, OP_STD,  3'd1, 3'd2, 3'd4, 1'b0, 1'b1);
    do_cycle("sat", 1'b1, OP_ADDI, 3'd1, 3'd2, 3'd5, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++)
      do_cycle("sat", 1'b1, OP_R2, 3'd1, 3'd2, 3'd6, 1'b0, 1'b0);
    check("sat.count", 32'(stall_count), 32'd15);
    rst = 1'b0;
    #1;
    check("arst.in_ready", 32'(in_ready), 32'd0);
    check("arst.all", 32'({ex_valid, ex_alu_src, ex_jump, ex_rd, mem_valid, mem_read,
                           mem_write, wb_valid, wb_regwrite, wb_mem_to_reg, wb_rd}), 32'd0);
    check("arst.count", 32'(stall_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("arst_release");
    do_cycle("post", 1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    check("post.empty", 32'({ex_valid, mem_valid, wb_valid}), 32'd0);

    // Randomized traffic against the model, with periodic resets
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) do_reset();
      do_cycle("rand",
               ($urandom_range(0, 3) != 0),
               OW'($urandom_range(0, 31)),
               AW'($urandom_range(0, 3)),
               AW'($urandom_range(0, 3)),
               AW'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
